// File: rtl/iter_alu_p.sv
// ============================================================================
// iter_alu_p : multi-cycle WIDTH-bit mul/div/shift/avg coprocessor
// Rev 1.0
// ============================================================================
`default_nettype none

module iter_alu_p #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid,
   input  logic [2:0]           mode,
   input  logic [WIDTH-1:0]     in_A,
   input  logic [WIDTH-1:0]     in_B,
   output logic                 busy,
   output logic                 ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 dz,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL   = 3'd1,
      S_DIV   = 3'd2,
      S_SHIFT = 3'd3,
      S_AVG   = 3'd4,
      S_BAD   = 3'd5,
      S_OUT   = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_p;
   logic                 r_neg;
   logic                 r_dz;
   logic                 r_err;

   logic                 w_signed;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_mul_sum;
   logic [WIDTH:0]       w_div_trial;
   logic [WIDTH-1:0]     w_div_rem;
   logic [WIDTH:0]       w_avg_sum;

   assign w_signed  = (mode == 3'd4);
   assign w_a_mag   = in_A[WIDTH-1] ? -in_A : in_A;
   assign w_b_mag   = in_B[WIDTH-1] ? -in_B : in_B;

   // r_p holds {partial product, remaining multiplier} during MUL
   // and {remainder, dividend/quotient} during DIV.
   assign w_mul_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
   assign w_div_trial = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]} - {1'b0, r_b};
   assign w_div_rem   = w_div_trial[WIDTH] ? {r_p[2*WIDTH-2:WIDTH], r_p[WIDTH-1]}
                                           : w_div_trial[WIDTH-1:0];
   assign w_avg_sum   = {1'b0, r_a} + {1'b0, r_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      ready       = 1'b0;
      out         = '0;
      dz          = 1'b0;
      err         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid) begin
               case (mode)
                  3'd0, 3'd4: w_state_nxt = S_MUL;
                  3'd1:       w_state_nxt = S_DIV;
                  3'd2:       w_state_nxt = S_SHIFT;
                  3'd3:       w_state_nxt = S_AVG;
                  default:    w_state_nxt = S_BAD;
               endcase
            end
         end
         S_MUL, S_DIV: if (r_cnt == c_last) w_state_nxt = S_OUT;
         S_SHIFT, S_AVG, S_BAD: w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      busy = (r_state != S_IDLE);
      if (r_state == S_OUT) begin
         ready = 1'b1;
         out   = r_neg ? -r_p : r_p;
         dz    = r_dz;
         err   = r_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_p   <= '0;
         r_neg <= 1'b0;
         r_dz  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid) begin
                  r_cnt <= '0;
                  r_a   <= w_signed ? w_a_mag : in_A;
                  r_b   <= in_B;
                  r_neg <= w_signed & (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
                  r_dz  <= (mode == 3'd1) && (in_B == '0);
                  r_err <= 1'b0;
                  case (mode)
                     3'd0:    r_p <= {{WIDTH{1'b0}}, in_B};
                     3'd4:    r_p <= {{WIDTH{1'b0}}, w_b_mag};
                     3'd1:    r_p <= {{WIDTH{1'b0}}, in_A};
                     default: r_p <= '0;
                  endcase
               end
            end
            S_MUL: begin
               r_p   <= {w_mul_sum, r_p[WIDTH-1:1]};
               r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
            end
            S_DIV: begin
               r_p   <= {w_div_rem, r_p[WIDTH-2:0], ~w_div_trial[WIDTH]};
               r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
            end
            S_SHIFT: r_p <= {{WIDTH{1'b0}}, r_a >> r_b[CNT_W-1:0]};
            S_AVG:   r_p <= {{(WIDTH-1){1'b0}}, w_avg_sum} >> 1;
            S_BAD: begin
               r_p   <= '0;
               r_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
